// File: rtl/ahblite_slave_mux_pkg.sv
// Shared encodings for the AHB-Lite slave multiplexer: transfer types,
// response codes, port count and data-phase select indices.
package ahblite_slave_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned NUM_PORTS = 4;

    localparam int unsigned SEL_P0   = 0;
    localparam int unsigned SEL_P1   = 1;
    localparam int unsigned SEL_P2   = 2;
    localparam int unsigned SEL_P3   = 3;
    localparam int unsigned SEL_DEF  = 4;
    localparam int unsigned SEL_NONE = 5;
    localparam int unsigned SEL_W    = 6;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_NONE_OH = sel_t'(1) << SEL_NONE;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahblite_slave_mux_default_slave.sv
// Default slave: answers unmapped accesses with the two-cycle AHB ERROR
// response (wait+ERROR, then ready+ERROR).
module ahblite_default_slave
    import ahblite_slave_mux_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic def_load_i,
    output logic hreadyout_o,
    output logic hresp_o
);

    ds_state_e state_q, state_d;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ERR2 may chain straight into ERR1 for back-to-back unmapped transfers.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (def_load_i) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = def_load_i ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        case (state_q)
            DS_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
            end
            DS_ERR2: begin
                hreadyout_o = 1'b1;
                hresp_o     = HRESP_ERROR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave multiplexer: registers the address-phase port choice into a
// one-hot data-phase select and muxes ready/response/read data back.
module ahblite_slave_mux
    import ahblite_slave_mux_pkg::*;
#(
    parameter bit Port0_en = 1'b1,
    parameter bit Port1_en = 1'b0,
    parameter bit Port2_en = 1'b0,
    parameter bit Port3_en = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    logic [NUM_PORTS-1:0] hsel_eff;
    sel_t                 sel_load;
    sel_t                 sel_d;
    sel_t                 sel_q;
    logic                 def_load;
    logic                 def_hreadyout;
    logic                 def_hresp;

    assign hsel_eff = {P3_HSEL & Port3_en, P2_HSEL & Port2_en,
                       P1_HSEL & Port1_en, P0_HSEL & Port0_en};

    always_comb begin
        sel_load = '0;
        if (hsel_eff[0])                sel_load[SEL_P0]   = 1'b1;
        else if (hsel_eff[1])           sel_load[SEL_P1]   = 1'b1;
        else if (hsel_eff[2])           sel_load[SEL_P2]   = 1'b1;
        else if (hsel_eff[3])           sel_load[SEL_P3]   = 1'b1;
        else if (htrans_active(HTRANS)) sel_load[SEL_DEF]  = 1'b1;
        else                            sel_load[SEL_NONE] = 1'b1;
    end

    // A stalled data phase (HREADY low) keeps its owner whatever HSEL does.
    assign sel_d    = HREADY ? sel_load : sel_q;
    assign def_load = HREADY & sel_load[SEL_DEF];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= SEL_NONE_OH;
        end else begin
            sel_q <= sel_d;
        end
    end

    ahblite_default_slave u_default_slave (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .def_load_i  (def_load),
        .hreadyout_o (def_hreadyout),
        .hresp_o     (def_hresp)
    );

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        if (sel_q[SEL_P0]) begin
            HREADYOUT = P0_HREADYOUT;
            HRESP     = P0_HRESP;
            HRDATA    = P0_HRDATA;
        end else if (sel_q[SEL_P1]) begin
            HREADYOUT = P1_HREADYOUT;
            HRESP     = P1_HRESP;
            HRDATA    = P1_HRDATA;
        end else if (sel_q[SEL_P2]) begin
            HREADYOUT = P2_HREADYOUT;
            HRESP     = P2_HRESP;
            HRDATA    = P2_HRDATA;
        end else if (sel_q[SEL_P3]) begin
            HREADYOUT = P3_HREADYOUT;
            HRESP     = P3_HRESP;
            HRDATA    = P3_HRDATA;
        end else if (sel_q[SEL_DEF]) begin
            HREADYOUT = def_hreadyout;
            HRESP     = def_hresp;
        end
    end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: transaction-level owner/error model checked
// every cycle, plus literal expectations for the key bus scenarios.
module tb_ahblite_slave_mux;

    localparam logic [3:0] EN_MASK = 4'b1011;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic [3:0]  hsel;
    logic [3:0]  p_rdy;
    logic [3:0]  p_resp;
    logic [31:0] p_data [4];
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    int n_checks = 0;
    int n_bad    = 0;

    // Model: owner 0..3 = port, 4 = default slave, 5 = nobody; err 0/1/2.
    int m_owner = 5;
    int m_err   = 0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahblite_slave_mux #(
        .Port0_en (1'b1),
        .Port1_en (1'b1),
        .Port2_en (1'b0),
        .Port3_en (1'b1)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HREADY       (HREADY),
        .HTRANS       (HTRANS),
        .P0_HSEL      (hsel[0]),
        .P1_HSEL      (hsel[1]),
        .P2_HSEL      (hsel[2]),
        .P3_HSEL      (hsel[3]),
        .P0_HREADYOUT (p_rdy[0]),
        .P1_HREADYOUT (p_rdy[1]),
        .P2_HREADYOUT (p_rdy[2]),
        .P3_HREADYOUT (p_rdy[3]),
        .P0_HRESP     (p_resp[0]),
        .P1_HRESP     (p_resp[1]),
        .P2_HRESP     (p_resp[2]),
        .P3_HRESP     (p_resp[3]),
        .P0_HRDATA    (p_data[0]),
        .P1_HRDATA    (p_data[1]),
        .P2_HRDATA    (p_data[2]),
        .P3_HRDATA    (p_data[3]),
        .HREADYOUT    (HREADYOUT),
        .HRESP        (HRESP),
        .HRDATA       (HRDATA)
    );

    function automatic int pick_owner(input logic [3:0] sel, input logic [1:0] tr);
        for (int i = 0; i < 4; i++) begin
            if (sel[i] && EN_MASK[i]) return i;
        end
        return (tr >= 2'd2) ? 4 : 5;
    endfunction

    function automatic logic exp_rdy();
        if (m_owner < 4) return p_rdy[m_owner];
        if (m_owner == 4) return (m_err != 1);
        return 1'b1;
    endfunction

    function automatic logic exp_resp();
        if (m_owner < 4) return p_resp[m_owner];
        if (m_owner == 4) return (m_err != 0);
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_data();
        if (m_owner < 4) return p_data[m_owner];
        return 32'h0;
    endfunction

    always @(posedge HCLK or posedge HRESET) begin : model
        int nxt;
        if (HRESET) begin
            m_owner <= 5;
            m_err   <= 0;
        end else if (exp_rdy()) begin
            nxt = pick_owner(hsel, HTRANS);
            m_owner <= nxt;
            m_err   <= (nxt == 4) ? 1 : 0;
        end else if (m_err == 1) begin
            m_err <= 2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        check("cyc_hreadyout", {31'b0, HREADYOUT}, {31'b0, exp_rdy()});
        check("cyc_hresp",     {31'b0, HRESP},     {31'b0, exp_resp()});
        check("cyc_hrdata",    HRDATA,             exp_data());
    end

    task automatic lit(input string name, input logic rdy, input logic resp, input logic [31:0] data);
        check({name, "_hreadyout"}, {31'b0, HREADYOUT}, {31'b0, rdy});
        check({name, "_hresp"},     {31'b0, HRESP},     {31'b0, resp});
        check({name, "_hrdata"},    HRDATA,             data);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge HCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1;
        HTRANS = 2'd0;
        hsel   = 4'b0000;
        p_rdy  = 4'b1111;
        p_resp = 4'b0000;
        p_data[0] = 32'h1000_0000;
        p_data[1] = 32'h1111_1111;
        p_data[2] = 32'h2222_2222;
        p_data[3] = 32'h3333_3333;
        tick();
        at_neg();
        lit("reset", 1'b1, 1'b0, 32'h0);
        tick();
        HRESET = 1'b0;

        // Zero-wait read from P0
        hsel = 4'b0001; HTRANS = 2'd2;
        tick();
        hsel = 4'b0000; HTRANS = 2'd0; p_data[0] = 32'h1234_5678;
        at_neg();
        lit("zero_wait", 1'b1, 1'b0, 32'h1234_5678);
        tick();

        // Wait-state hold on P0 while P1 is presented
        hsel = 4'b0001; HTRANS = 2'd2;
        tick();
        p_rdy[0] = 1'b0; p_data[0] = 32'hCAFE_0000; p_data[1] = 32'hAAAA_5555;
        hsel = 4'b0010; HTRANS = 2'd2;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            lit("wait_hold", 1'b0, 1'b0, 32'hCAFE_0000);
            tick();
        end
        p_rdy[0] = 1'b1;
        at_neg();
        lit("wait_done", 1'b1, 1'b0, 32'hCAFE_0000);
        tick();
        hsel = 4'b0000; HTRANS = 2'd0;
        at_neg();
        lit("after_wait_p1", 1'b1, 1'b0, 32'hAAAA_5555);
        tick();

        // Unmapped NONSEQ
        HTRANS = 2'd2;
        tick();
        HTRANS = 2'd0;
        at_neg(); lit("unmapped_err1", 1'b0, 1'b1, 32'h0);
        tick();
        at_neg(); lit("unmapped_err2", 1'b1, 1'b1, 32'h0);
        tick();
        at_neg(); lit("unmapped_idle", 1'b1, 1'b0, 32'h0);

        // Back-to-back unmapped
        HTRANS = 2'd2;
        tick();
        at_neg(); lit("b2b_err1a", 1'b0, 1'b1, 32'h0);
        tick();
        at_neg(); lit("b2b_err2a", 1'b1, 1'b1, 32'h0);
        tick();
        HTRANS = 2'd0;
        at_neg(); lit("b2b_err1b", 1'b0, 1'b1, 32'h0);
        tick();
        at_neg(); lit("b2b_err2b", 1'b1, 1'b1, 32'h0);
        tick();
        at_neg(); lit("b2b_idle", 1'b1, 1'b0, 32'h0);

        // Disabled port (P2) selected with NONSEQ, then BUSY with nothing selected
        hsel = 4'b0100; HTRANS = 2'd2;
        tick();
        hsel = 4'b0000; HTRANS = 2'd0;
        at_neg(); lit("disabled_err1", 1'b0, 1'b1, 32'h0);
        tick();
        at_neg(); lit("disabled_err2", 1'b1, 1'b1, 32'h0);
        HTRANS = 2'd1;
        tick();
        at_neg(); lit("busy_okay", 1'b1, 1'b0, 32'h0);
        tick();
        at_neg(); lit("busy_okay2", 1'b1, 1'b0, 32'h0);
        HTRANS = 2'd0;

        // Priority among simultaneous selects
        p_data[0] = 32'hA000_0000; p_data[1] = 32'hA111_0000;
        p_data[2] = 32'hA222_0000; p_data[3] = 32'hA333_0000;
        hsel = 4'b1111; HTRANS = 2'd2;
        tick();
        hsel = 4'b1110;
        at_neg(); lit("prio_p0", 1'b1, 1'b0, 32'hA000_0000);
        tick();
        hsel = 4'b1100;
        at_neg(); lit("prio_p1", 1'b1, 1'b0, 32'hA111_0000);
        tick();
        hsel = 4'b0100; HTRANS = 2'd0;
        at_neg(); lit("prio_p3", 1'b1, 1'b0, 32'hA333_0000);
        tick();
        hsel = 4'b0000;
        at_neg(); lit("disabled_idle", 1'b1, 1'b0, 32'h0);
        tick();

        // Two-cycle slave ERROR from P3 passed through
        hsel = 4'b1000; HTRANS = 2'd2;
        tick();
        hsel = 4'b0000; HTRANS = 2'd0; p_resp[3] = 1'b1; p_rdy[3] = 1'b0;
        at_neg(); lit("slv_err1", 1'b0, 1'b1, 32'hA333_0000);
        tick();
        p_rdy[3] = 1'b1;
        at_neg(); lit("slv_err2", 1'b1, 1'b1, 32'hA333_0000);
        tick();
        p_resp[3] = 1'b0;
        at_neg(); lit("slv_after", 1'b1, 1'b0, 32'h0);

        // Asynchronous reset in the middle of ERR1
        HTRANS = 2'd2;
        tick();
        HTRANS = 2'd0;
        #2;
        HRESET = 1'b1;
        #1;
        lit("async_rst", 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        HRESET = 1'b0;

        // First edge after reset loads normally
        hsel = 4'b0001; HTRANS = 2'd2;
        tick();
        hsel = 4'b0000; HTRANS = 2'd0; p_data[0] = 32'h5A5A_A5A5;
        at_neg(); lit("post_rst_load", 1'b1, 1'b0, 32'h5A5A_A5A5);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ahblite_slave_mux.md
AHBLITE_SLAVE_MUX -- requirements
Module: ahblite_slave_mux

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- Port0_en, 1, RAMCODE port enable.
- Port1_en, 0, RAMDATA port enable.
- Port2_en, 0, WaterLight port enable.
- Port3_en, 0, UART port enable.

REQ-002 The block SHALL have exactly one clock and an asynchronous, active-high reset. Ports, one per line (name, direction, width, meaning):
- HCLK, in, 1, bus clock.
- HRESET, in, 1, asynchronous active-high reset.
- HREADY, in, 1, bus-level ready; equals HREADYOUT fed back by the interconnect.
- HTRANS, in, 2, address-phase transfer type.
- P0_HSEL..P3_HSEL, in, 1 each, address-phase port selects from the address decoder.
- P0_HREADYOUT..P3_HREADYOUT, in, 1 each, slave ready.
- P0_HRESP..P3_HRESP, in, 1 each, slave response (0=OKAY, 1=ERROR).
- P0_HRDATA..P3_HRDATA, in, 32 each, slave read data.
- HREADYOUT, out, 1, muxed ready to the master.
- HRESP, out, 1, muxed response.
- HRDATA, out, 32, muxed read data.

Function
REQ-003 The block SHALL hold a data-phase select register, sel_q, one-hot over {P0, P1, P2, P3, DEF, NONE}.
REQ-004 sel_q SHALL load only on HCLK rising edges where HREADY=1, and SHALL hold otherwise.
REQ-005 Port n SHALL be effective only if Pn_HSEL=1 and Portn_en=1.
REQ-006 If several ports are effective, priority SHALL be P0>P1>P2>P3.
REQ-007 Load value when HREADY=1:
- any port effective: highest-priority effective port;
- else HTRANS[1]=1 (NONSEQ/SEQ): DEF;
- else: NONE.
REQ-008 With sel_q=Pn, HREADYOUT, HRESP and HRDATA SHALL equal Pn_HREADYOUT, Pn_HRESP and Pn_HRDATA combinationally, with zero added latency.
REQ-009 With sel_q=NONE: HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-010 The default slave SHALL be an FSM with states IDLE, ERR1 and ERR2.
REQ-011 Default-slave transitions and outputs:
- IDLE->ERR1 when sel_q loads DEF;
- ERR1 outputs HREADYOUT=0, HRESP=1, then goes to ERR2 unconditionally;
- ERR2 outputs HREADYOUT=1, HRESP=1, then goes to IDLE, or to ERR1 if DEF is loaded again in the same cycle (back-to-back unmapped accesses).
REQ-012 HRDATA SHALL be 0 whenever the FSM is in ERR1 or ERR2.
REQ-013 An IDLE or BUSY HTRANS with no port selected SHALL produce a zero-wait OKAY and SHALL NOT enter ERR1.
REQ-014 A slave wait state (Pn_HREADYOUT=0) SHALL hold sel_q on Pn until it completes, regardless of address-phase HSEL changes.
REQ-015 A slave ERROR (Pn_HRESP=1) SHALL be passed through unchanged, including its two-cycle form.

Reset
REQ-016 Asserting HRESET SHALL immediately set sel_q=NONE and FSM=IDLE, giving HREADYOUT=1, HRESP=0, HRDATA=0, including mid-transfer and mid-ERR1/ERR2.
REQ-017 After HRESET deasserts, the first HCLK edge with HREADY=1 SHALL perform a normal REQ-007 load.

Structure
REQ-018 A shared package SHALL hold the HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), the HRESP codes, the port count (4) and the sel_q one-hot indices.
REQ-019 The default-slave FSM SHALL be one sub-module, ahblite_default_slave, instantiated once.
REQ-020 The select register and output mux SHALL reside in the top module.

Verification
REQ-021 Zero-wait read: P0_HSEL=1, HTRANS=2, P0_HRDATA=0x12345678 in the data phase -> HRDATA=0x12345678, HREADYOUT=1, HRESP=0 one cycle after the address phase.
REQ-022 Wait-state hold: P0 selected, P0_HREADYOUT=0 for 3 cycles, P1_HSEL=1 presented during the wait -> HRDATA follows P0 throughout; P1 is selected only after P0_HREADYOUT=1.
REQ-023 Unmapped access: address 0x50000000, all HSEL=0, HTRANS=2 -> HREADYOUT,HRESP = (0,1) then (1,1), then (1,0) in IDLE.
REQ-024 Back-to-back unmapped: two NONSEQ transfers with all HSEL=0 -> ERR1, ERR2, ERR1, ERR2 with no intervening OKAY cycle.
REQ-025 Disabled port / idle transfer: Port1_en=0 with P1_HSEL=1 and HTRANS=2 -> error sequence; any HTRANS=0 with all HSEL=0 -> HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-026 Reset mid-ERR1: assert HRESET while in ERR1 -> HREADYOUT=1 and HRESP=0 immediately, without waiting for a clock edge.
